apb_master: RTL

- Single-outstanding APB initiator. Converts a valid/ready command stream (address, direction, write data) into APB SETUP/ACCESS transfers and returns a valid/ready response with read data.
- Drives APB peripherals such as the GPIO8 APB slave from a local controller.
- Also serves as the synthesizable initiator for bench and system bring-up.

---
 rtl/apb_master_if.sv | 28 ++
 rtl/apb_master.sv | 67 ++++++
 2 files changed

// File: rtl/apb_master_if.sv
// apb_master_if: command/response stream plus APB bus signals of the apb_master initiator
interface apb_master_if #(parameter int AW = 32, parameter int DW = 32);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, PADDR, PWRITE, PSEL, PENABLE, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator; ACCESS timeout abort enabled by APB_MASTER_TIMEOUT_EN
module apb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic PCLK,
  input logic PRESET,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic write_q;
  logic done, abort;
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("apb_master: TIMEOUT must be in 1..255");
  end
  assign done = state == ACCESS && (bus.PREADY || abort);
`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] cnt;
  logic err_q;
  // abort on the TIMEOUT-th waiting ACCESS cycle; PREADY in that same cycle still wins
  assign abort = state == ACCESS && !bus.PREADY && cnt == 8'(TIMEOUT - 1);
  always_ff @(posedge PCLK) begin
    cnt <= (PRESET || state != ACCESS) ? 8'd0 : cnt + {7'd0, !bus.PREADY};
    if (PRESET) err_q <= 1'b0;
    else if (done) err_q <= abort;
  end
  assign bus.rsp_err = err_q;
`else
  assign abort = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  always_ff @(posedge PCLK)
    state <= PRESET ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE   ? (bus.cmd_valid ? SETUP : IDLE)
             : state == SETUP  ? ACCESS
             : state == ACCESS ? (done ? RESP : ACCESS)
             : (bus.rsp_ready ? IDLE : RESP);
    bus.cmd_ready = state == IDLE;
    bus.PSEL      = state == SETUP || state == ACCESS;
    bus.PENABLE   = state == ACCESS;
    bus.rsp_valid = state == RESP;
    bus.busy      = state != IDLE;
  end
  always_ff @(posedge PCLK)
    if (PRESET) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && bus.cmd_valid) begin
        addr_q  <= bus.cmd_addr;
        write_q <= bus.cmd_write;
        wdata_q <= bus.cmd_wdata;
      end
      if (done) rdata_q <= (write_q || abort) ? '0 : bus.PRDATA;
    end
  assign bus.PADDR     = addr_q;
  assign bus.PWRITE    = write_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.rsp_rdata = rdata_q;
endmodule
